// File: rtl/sb_tx_msg_arbiter_if.sv
// Sideband TX message arbiter bundle: two requesters, encoder fields, serializer done and status.
// master = arbiter side, slave = requesters/encoder/serializer side.
interface sb_tx_msg_arbiter_if;
  logic       i_ltsm_req;
  logic [3:0] i_ltsm_state;
  logic [3:0] i_ltsm_sub_state;
  logic [3:0] i_ltsm_msg_no;
  logic [2:0] i_ltsm_msg_info;
  logic       i_ltsm_data_valid;
  logic       o_ltsm_ack;

  logic       i_pt_req;
  logic [1:0] i_pt_test;
  logic [3:0] i_pt_msg_no;
  logic [2:0] i_pt_msg_info;
  logic       i_pt_data_valid;
  logic       o_pt_ack;

  logic       o_msg_valid;
  logic       o_data_valid;
  logic [3:0] o_state;
  logic [3:0] o_sub_state;
  logic [3:0] o_msg_no;
  logic [2:0] o_msg_info;
  logic       o_tx_point_sweep_test_en;
  logic [1:0] o_tx_point_sweep_test;

  logic       i_ser_done;
  logic       o_busy;
  logic       o_timeout_err;

  modport master (
    input  i_ltsm_req, i_ltsm_state, i_ltsm_sub_state, i_ltsm_msg_no, i_ltsm_msg_info,
           i_ltsm_data_valid, i_pt_req, i_pt_test, i_pt_msg_no, i_pt_msg_info,
           i_pt_data_valid, i_ser_done,
    output o_ltsm_ack, o_pt_ack, o_msg_valid, o_data_valid, o_state, o_sub_state,
           o_msg_no, o_msg_info, o_tx_point_sweep_test_en, o_tx_point_sweep_test,
           o_busy, o_timeout_err
  );

  modport slave (
    output i_ltsm_req, i_ltsm_state, i_ltsm_sub_state, i_ltsm_msg_no, i_ltsm_msg_info,
           i_ltsm_data_valid, i_pt_req, i_pt_test, i_pt_msg_no, i_pt_msg_info,
           i_pt_data_valid, i_ser_done,
    input  o_ltsm_ack, o_pt_ack, o_msg_valid, o_data_valid, o_state, o_sub_state,
           o_msg_no, o_msg_info, o_tx_point_sweep_test_en, o_tx_point_sweep_test,
           o_busy, o_timeout_err
  );
endinterface

// File: rtl/sb_tx_msg_arbiter.sv
// Round-robin arbiter of LTSM and point/sweep test messages onto the sideband TX header encoder.
// Optional WAIT_DONE watchdog enabled by defining SB_TX_ARB_TIMEOUT_EN.
module sb_tx_msg_arbiter #(
  parameter int GAP_CYCLES     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  sb_tx_msg_arbiter_if.master  bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} state_t;

  localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state_q;
  logic             last_pt_q;
  logic [CNT_W-1:0] cnt_q;
  logic             msg_valid_q, ltsm_ack_q, pt_ack_q;
  logic             data_valid_q, pt_en_q;
  logic [3:0]       st_q, sub_q, no_q;
  logic [2:0]       info_q;
  logic [1:0]       pt_test_q;

  logic grant_ltsm, grant_pt, pkt_end;

  // Ties go to whoever was not granted last; a lone request always wins.
  assign grant_ltsm = bus.i_ltsm_req && (!bus.i_pt_req || last_pt_q);
  assign grant_pt   = bus.i_pt_req && !grant_ltsm;

`ifdef SB_TX_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  logic tmo_q;
  assign pkt_end = bus.i_ser_done || (cnt_q == TMO_LAST);
  assign bus.o_timeout_err = tmo_q;
`else
  assign pkt_end = bus.i_ser_done;
  assign bus.o_timeout_err = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      last_pt_q    <= 1'b1;
      cnt_q        <= '0;
      msg_valid_q  <= 1'b0;
      ltsm_ack_q   <= 1'b0;
      pt_ack_q     <= 1'b0;
      data_valid_q <= 1'b0;
      pt_en_q      <= 1'b0;
      st_q         <= '0;
      sub_q        <= '0;
      no_q         <= '0;
      info_q       <= '0;
      pt_test_q    <= '0;
`ifdef SB_TX_ARB_TIMEOUT_EN
      tmo_q        <= 1'b0;
`endif
    end else begin
      msg_valid_q <= 1'b0;
      ltsm_ack_q  <= 1'b0;
      pt_ack_q    <= 1'b0;
`ifdef SB_TX_ARB_TIMEOUT_EN
      tmo_q       <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (grant_ltsm) begin
            state_q      <= ISSUE;
            last_pt_q    <= 1'b0;
            msg_valid_q  <= 1'b1;
            ltsm_ack_q   <= 1'b1;
            data_valid_q <= bus.i_ltsm_data_valid;
            st_q         <= bus.i_ltsm_state;
            sub_q        <= bus.i_ltsm_sub_state;
            no_q         <= bus.i_ltsm_msg_no;
            info_q       <= bus.i_ltsm_msg_info;
            pt_en_q      <= 1'b0;
            pt_test_q    <= 2'd0;
          end else if (grant_pt) begin
            state_q      <= ISSUE;
            last_pt_q    <= 1'b1;
            msg_valid_q  <= 1'b1;
            pt_ack_q     <= 1'b1;
            data_valid_q <= bus.i_pt_data_valid;
            st_q         <= 4'd4;  // MBTRAIN
            sub_q        <= 4'd0;
            no_q         <= bus.i_pt_msg_no;
            info_q       <= bus.i_pt_msg_info;
            pt_en_q      <= 1'b1;
            pt_test_q    <= bus.i_pt_test;
          end
        end
        ISSUE: begin
          state_q <= WAIT_DONE;
          cnt_q   <= '0;
        end
        WAIT_DONE: begin
          if (pkt_end) begin
`ifdef SB_TX_ARB_TIMEOUT_EN
            tmo_q <= !bus.i_ser_done;
`endif
            if (GAP_CYCLES == 0) begin
              state_q <= IDLE;
            end else begin
              state_q <= GAP;
              cnt_q   <= GAP_LOAD;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt_q == '0) state_q <= IDLE;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_msg_valid              = msg_valid_q;
  assign bus.o_ltsm_ack               = ltsm_ack_q;
  assign bus.o_pt_ack                 = pt_ack_q;
  assign bus.o_data_valid             = data_valid_q;
  assign bus.o_state                  = st_q;
  assign bus.o_sub_state              = sub_q;
  assign bus.o_msg_no                 = no_q;
  assign bus.o_msg_info               = info_q;
  assign bus.o_tx_point_sweep_test_en = pt_en_q;
  assign bus.o_tx_point_sweep_test    = pt_test_q;
  assign bus.o_busy                   = (state_q != IDLE);
endmodule

// File: tb/tb_sb_tx_msg_arbiter.sv
// Directed self-checking bench for sb_tx_msg_arbiter (GAP_CYCLES=32, TIMEOUT_CYCLES=16).
module tb_sb_tx_msg_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sb_tx_msg_arbiter_if bus();
  sb_tx_msg_arbiter #(.GAP_CYCLES(32), .TIMEOUT_CYCLES(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
  );

  int total = 0;
  int bad = 0;
  int n_valid = 0, n_ltsm = 0, n_pt = 0, n_tmo = 0;

  always @(negedge clk) begin
    if (bus.o_msg_valid === 1'b1) n_valid++;
    if (bus.o_ltsm_ack === 1'b1) n_ltsm++;
    if (bus.o_pt_ack === 1'b1) n_pt++;
    if (bus.o_timeout_err === 1'b1) n_tmo++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ticks until IDLE (bounded); optionally pulses i_ser_done at iteration pulse_at.
  task automatic count_gap(input int pulse_at, output int n);
    n = 0;
    while (bus.o_busy === 1'b1 && n < 100) begin
      if (n == pulse_at) bus.i_ser_done = 1'b1;
      tick();
      bus.i_ser_done = 1'b0;
      n++;
    end
  endtask

  int n;
  int k;
  logic ok;

  initial begin
    bus.i_ltsm_req = 0; bus.i_ltsm_state = 0; bus.i_ltsm_sub_state = 0;
    bus.i_ltsm_msg_no = 0; bus.i_ltsm_msg_info = 0; bus.i_ltsm_data_valid = 0;
    bus.i_pt_req = 0; bus.i_pt_test = 0; bus.i_pt_msg_no = 0;
    bus.i_pt_msg_info = 0; bus.i_pt_data_valid = 0; bus.i_ser_done = 0;

    // Reset state
    tick(); tick();
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_valid", bus.o_msg_valid, 0);
    chk("rst_state", bus.o_state, 0);
    chk("rst_msg_no", bus.o_msg_no, 0);
    chk("rst_tmo", bus.o_timeout_err, 0);
    rst_n = 1'b1;

    // Single LTSM request
    bus.i_ltsm_state = 4'd3; bus.i_ltsm_sub_state = 4'd2; bus.i_ltsm_msg_no = 4'd1;
    bus.i_ltsm_msg_info = 3'd5; bus.i_ltsm_data_valid = 1'b1; bus.i_ltsm_req = 1'b1;
    tick();
    chk("ltsm_valid", bus.o_msg_valid, 1);
    chk("ltsm_ack", bus.o_ltsm_ack, 1);
    chk("ltsm_pt_ack", bus.o_pt_ack, 0);
    chk("ltsm_state", bus.o_state, 3);
    chk("ltsm_sub", bus.o_sub_state, 2);
    chk("ltsm_msg_no", bus.o_msg_no, 1);
    chk("ltsm_info", bus.o_msg_info, 5);
    chk("ltsm_dv", bus.o_data_valid, 1);
    chk("ltsm_pt_en", bus.o_tx_point_sweep_test_en, 0);
    bus.i_ltsm_req = 1'b0;
    tick();
    chk("ltsm_valid_1cyc", bus.o_msg_valid, 0);
    chk("ltsm_hold_state", bus.o_state, 3);
    chk("ltsm_busy", bus.o_busy, 1);
    tick(); tick(); tick();
    chk("wait_busy", bus.o_busy, 1);
    bus.i_ser_done = 1'b1; tick(); bus.i_ser_done = 1'b0;
    count_gap(-1, n);
    chk("gap1", n, 32);
    chk("cnt_valid_a", n_valid, 1);

    // PT request; done during ISSUE and during GAP must be ignored
    bus.i_pt_test = 2'd2; bus.i_pt_msg_no = 4'd6; bus.i_pt_msg_info = 3'd3;
    bus.i_pt_data_valid = 1'b0; bus.i_pt_req = 1'b1;
    tick();
    chk("pt_ack", bus.o_pt_ack, 1);
    chk("pt_valid", bus.o_msg_valid, 1);
    chk("pt_state", bus.o_state, 4);
    chk("pt_sub", bus.o_sub_state, 0);
    chk("pt_en", bus.o_tx_point_sweep_test_en, 1);
    chk("pt_test", bus.o_tx_point_sweep_test, 2);
    chk("pt_msg_no", bus.o_msg_no, 6);
    bus.i_pt_req = 1'b0; bus.i_ser_done = 1'b1;
    tick();
    bus.i_ser_done = 1'b0;
    repeat (5) tick();
    chk("issue_done_ignored", bus.o_busy, 1);
    bus.i_ser_done = 1'b1; tick(); bus.i_ser_done = 1'b0;
    count_gap(10, n);
    chk("gap_done_ignored", n, 32);
    chk("cnt_pt_b", n_pt, 1);
    chk("cnt_valid_b", n_valid, 2);

    // Tie after PT grant goes to LTSM; PT withdraws before its ack
    bus.i_ltsm_state = 4'd9; bus.i_ltsm_msg_no = 4'd4;
    bus.i_ltsm_req = 1'b1; bus.i_pt_req = 1'b1;
    tick();
    chk("wd_ltsm_ack", bus.o_ltsm_ack, 1);
    bus.i_ltsm_req = 1'b0;
    tick(); tick();
    bus.i_pt_req = 1'b0;
    tick(); tick();
    bus.i_ser_done = 1'b1; tick(); bus.i_ser_done = 1'b0;
    count_gap(-1, n);
    tick(); tick(); tick();
    chk("wd_no_pt_ack", n_pt, 1);
    chk("wd_valid_cnt", n_valid, 3);

    // Reset in WAIT_DONE
    bus.i_ltsm_req = 1'b1;
    tick();
    bus.i_ltsm_req = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", bus.o_busy, 0);
    chk("mid_rst_state", bus.o_state, 0);
    chk("mid_rst_msg_no", bus.o_msg_no, 0);
    chk("mid_rst_dv", bus.o_data_valid, 0);
    tick(); tick();
    rst_n = 1'b1;

    // Both held: strict alternation starting with LTSM after reset
    bus.i_ltsm_state = 4'd5; bus.i_ltsm_msg_no = 4'd2;
    bus.i_pt_test = 2'd3; bus.i_pt_msg_no = 4'd7;
    bus.i_ltsm_req = 1'b1; bus.i_pt_req = 1'b1;
    for (int p = 0; p < 4; p++) begin
      k = 0;
      while (bus.o_msg_valid !== 1'b1 && k < 10) begin tick(); k++; end
      chk("rr_valid", bus.o_msg_valid, 1);
      chk("rr_ltsm_ack", bus.o_ltsm_ack, (p % 2 == 0));
      chk("rr_pt_ack", bus.o_pt_ack, (p % 2 == 1));
      chk("rr_msg_no", bus.o_msg_no, (p % 2 == 0) ? 2 : 7);
      tick(); tick();
      bus.i_ser_done = 1'b1; tick(); bus.i_ser_done = 1'b0;
      count_gap(-1, n);
      chk("rr_gap", n, 32);
    end
    bus.i_ltsm_req = 1'b0; bus.i_pt_req = 1'b0;
    tick(); tick();
    chk("rr_valid_cnt", n_valid, 8);
    chk("rr_idle", bus.o_busy, 0);

`ifdef SB_TX_ARB_TIMEOUT_EN
    // Watchdog: no done arrives
    bus.i_ltsm_req = 1'b1;
    tick();
    bus.i_ltsm_req = 1'b0;
    tick();
    k = 0;
    while (bus.o_timeout_err !== 1'b1 && k < 100) begin tick(); k++; end
    chk("tmo_cycles", k, 16);
    chk("tmo_busy", bus.o_busy, 1);
    count_gap(-1, n);
    chk("tmo_gap", n, 32);
    chk("tmo_pulses", n_tmo, 1);
`else
    // No watchdog: WAIT_DONE holds indefinitely
    bus.i_ltsm_req = 1'b1;
    tick();
    bus.i_ltsm_req = 1'b0;
    ok = 1'b1;
    repeat (60) begin
      tick();
      if (bus.o_busy !== 1'b1 || bus.o_timeout_err !== 1'b0) ok = 1'b0;
    end
    chk("no_tmo_hold", ok, 1);
    bus.i_ser_done = 1'b1; tick(); bus.i_ser_done = 1'b0;
    count_gap(-1, n);
    chk("no_tmo_gap", n, 32);
    chk("no_tmo_pulses", n_tmo, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
